// File: rtl/hs_ram_responder.sv
// Hiscore request responder: slots hiscore RAM accesses into CPU-idle cycles
// and forces a one-cycle CPU stall after MAX_WAIT consecutive busy cycles.
module hs_ram_responder #(
  parameter int AW       = 11,
  parameter int DW       = 8,
  parameter int MAX_WAIT = 64
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          hs_access,
  input  logic          hs_req,
  input  logic          hs_write,
  input  logic [AW-1:0] hs_address,
  input  logic [DW-1:0] hs_data_in,
  output logic [DW-1:0] hs_data_out,
  output logic          hs_ready,
  output logic          hs_busy,
  input  logic          cpu_ram_en,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  output logic [DW-1:0] cpu_dout,
  output logic          cpu_hold,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  input  logic [DW-1:0] ram_dout
);

  localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RD_LAT, S_DONE} state_t;

  state_t        state_q;
  logic [CW-1:0] wait_cnt_q;
  logic          req_we_q;
  logic [AW-1:0] req_addr_q;
  logic [DW-1:0] req_data_q;
  logic [DW-1:0] rdata_q;
  logic          wait_max;
  logic          grant;

  assign wait_max = (wait_cnt_q == CW'(MAX_WAIT));
  // Grant resolves in the same cycle so an idle CPU cycle is never wasted.
  assign grant    = (state_q == S_WAIT) && (!cpu_ram_en || wait_max);
  assign cpu_hold = grant && cpu_ram_en;

  assign hs_ready    = (state_q == S_DONE);
  assign hs_busy     = (state_q != S_IDLE);
  assign hs_data_out = rdata_q;
  assign cpu_dout    = ram_dout;

  always_comb begin
    ram_addr = cpu_addr;
    ram_din  = cpu_din;
    ram_we   = cpu_we && cpu_ram_en;
    if (grant) begin
      ram_addr = req_addr_q;
      ram_din  = req_data_q;
      ram_we   = req_we_q;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      req_we_q   <= 1'b0;
      req_addr_q <= '0;
      req_data_q <= '0;
      rdata_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (hs_req && hs_access) begin
            req_we_q   <= hs_write;
            req_addr_q <= hs_address;
            req_data_q <= hs_data_in;
            state_q    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (grant) begin
            state_q <= req_we_q ? S_DONE : S_RD_LAT;
          end else if (!wait_max) begin
            wait_cnt_q <= wait_cnt_q + CW'(1);
          end
        end
        S_RD_LAT: begin
          rdata_q <= ram_dout;
          state_q <= S_DONE;
        end
        S_DONE: begin
          wait_cnt_q <= '0;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hs_ram_responder.sv
// Bench for hs_ram_responder: vector table of hiscore transactions plus
// hand sequences for starvation, ignored requests, abort and access drop.
module tb_hs_ram_responder;

  localparam int AW = 11;
  localparam int DW = 8;

  logic          clk_sys = 1'b0;
  logic          reset_n = 1'b0;
  logic          hs_access = 1'b0;
  logic          hs_req = 1'b0;
  logic          hs_write = 1'b0;
  logic [AW-1:0] hs_address = '0;
  logic [DW-1:0] hs_data_in = '0;
  logic [DW-1:0] hs_data_out;
  logic          hs_ready;
  logic          hs_busy;
  logic          cpu_ram_en = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_din = '0;
  logic [DW-1:0] cpu_dout;
  logic          cpu_hold;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_we;
  logic [DW-1:0] ram_dout = '0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_cmp = 0;
  int n_bad = 0;

  hs_ram_responder #(.AW(AW), .DW(DW), .MAX_WAIT(4)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .hs_access(hs_access), .hs_req(hs_req), .hs_write(hs_write),
    .hs_address(hs_address), .hs_data_in(hs_data_in),
    .hs_data_out(hs_data_out), .hs_ready(hs_ready), .hs_busy(hs_busy),
    .cpu_ram_en(cpu_ram_en), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_hold(cpu_hold),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .ram_dout(ram_dout)
  );

  always #5 clk_sys = ~clk_sys;

  // Single-port synchronous RAM, read-before-write, one-cycle read latency.
  always @(posedge clk_sys) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Runs one hiscore transaction starting in cycle 0; returns the cycle of
  // hs_ready (-1 on timeout), number of cpu_hold cycles, first hiscore
  // ram_we cycle and the address seen there.
  task automatic txn(input logic we, input logic [AW-1:0] addr,
                     input logic [DW-1:0] wdata, input int busy,
                     input int drop_acc, input int inj_req,
                     output int lat, output int holds,
                     output int we_cyc, output int we_addr);
    lat = -1; holds = 0; we_cyc = -1; we_addr = -1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk_sys); #1;
      hs_access  = !(drop_acc >= 0 && c >= drop_acc);
      hs_req     = (c == 0) || (c == inj_req);
      hs_write   = we;
      hs_address = (c == inj_req) ? addr + 11'd1 : addr;
      hs_data_in = (c == inj_req) ? ~wdata : wdata;
      cpu_ram_en = (c >= 1) && (c <= busy);
      cpu_we     = 1'b0;
      cpu_addr   = 11'h7A0;
      cpu_din    = 8'h00;
      @(negedge clk_sys);
      if (cpu_hold) holds++;
      if (ram_we && we_cyc < 0) begin
        we_cyc  = c;
        we_addr = int'(ram_addr);
      end
      if (hs_ready) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic idle_cycle(input logic [DW-1:0] exp_rd);
    @(posedge clk_sys); #1;
    hs_req = 1'b0; hs_access = 1'b1; cpu_ram_en = 1'b0; cpu_we = 1'b0;
    @(negedge clk_sys);
    chk("idle_ready", int'(hs_ready), 0);
    chk("idle_busy", int'(hs_busy), 0);
    chk("held_data", int'(hs_data_out), int'(exp_rd));
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            busy;
    int            exp_lat;
    int            exp_holds;
    logic [DW-1:0] exp_rd;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int lat, holds, we_cyc, we_addr, hc, rc;
    logic [DW-1:0] last_rd;
    logic ok;

    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;

    // MAX_WAIT=4: busy b<=4 grants at cycle b+1, b>=5 steals at cycle 5.
    vecs[0] = '{1'b1, 11'h1A3, 8'h5C, 0,  2, 0, 8'h00};
    vecs[1] = '{1'b0, 11'h1A3, 8'h00, 0,  3, 0, 8'h5C};
    vecs[2] = '{1'b1, 11'h07F, 8'hA5, 3,  5, 0, 8'h00};
    vecs[3] = '{1'b0, 11'h07F, 8'h00, 3,  6, 0, 8'hA5};
    vecs[4] = '{1'b1, 11'h000, 8'h11, 10, 6, 1, 8'h00};
    vecs[5] = '{1'b0, 11'h000, 8'h00, 10, 7, 1, 8'h11};
    vecs[6] = '{1'b1, 11'h7FF, 8'hFF, 0,  2, 0, 8'h00};
    vecs[7] = '{1'b0, 11'h7FF, 8'h00, 4,  7, 0, 8'hFF};

    // Reset state
    repeat (2) @(negedge clk_sys);
    chk("rst_ready", int'(hs_ready), 0);
    chk("rst_busy", int'(hs_busy), 0);
    chk("rst_data", int'(hs_data_out), 0);
    chk("rst_hold", int'(cpu_hold), 0);
    @(posedge clk_sys); #1;
    reset_n = 1'b1;

    // RAM follows CPU port while no request is pending
    for (int i = 0; i < 100; i++) begin
      @(posedge clk_sys); #1;
      cpu_ram_en = 1'($urandom_range(0, 1));
      cpu_we     = 1'($urandom_range(0, 1));
      cpu_addr   = 11'h400 | 11'($urandom_range(0, 255));
      cpu_din    = 8'($urandom);
      hs_access  = 1'($urandom_range(0, 1));
      @(negedge clk_sys);
      ok = (ram_addr == cpu_addr) && (ram_din == cpu_din) &&
           (ram_we == (cpu_we && cpu_ram_en)) && !cpu_hold && !hs_ready &&
           !hs_busy && (hs_data_out == 8'h00) && (cpu_dout == ram_dout);
      chk("cpu_follow", int'(ok), 1);
    end

    // Vector table
    last_rd = 8'h00;
    foreach (vecs[i]) begin
      txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].busy, -1, -1,
          lat, holds, we_cyc, we_addr);
      chk($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_holds", i), holds, vecs[i].exp_holds);
      if (vecs[i].we) begin
        chk($sformatf("v%0d_we_cyc", i), we_cyc, vecs[i].exp_lat - 1);
        chk($sformatf("v%0d_we_addr", i), we_addr, int'(vecs[i].addr));
      end else begin
        chk($sformatf("v%0d_no_we", i), we_cyc, -1);
        chk($sformatf("v%0d_rdata", i), int'(hs_data_out), int'(vecs[i].exp_rd));
        last_rd = vecs[i].exp_rd;
      end
      idle_cycle(last_rd);
      if (vecs[i].we)
        chk($sformatf("v%0d_mem", i), int'(mem[vecs[i].addr]), int'(vecs[i].wdata));
    end

    // Starvation: CPU writes every cycle, hiscore write steals WAIT cycle 5
    hc = -1; holds = 0; lat = -1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk_sys); #1;
      hs_access = 1'b1; hs_req = (c == 0); hs_write = 1'b1;
      hs_address = 11'h300; hs_data_in = 8'h3C;
      cpu_ram_en = 1'b1; cpu_we = 1'b1;
      cpu_addr = 11'h200 + 11'(c); cpu_din = 8'h80 + 8'(c);
      @(negedge clk_sys);
      if (cpu_hold) begin
        holds++;
        if (hc < 0) hc = c;
        chk("steal_addr", int'(ram_addr), 'h300);
      end
      if (hs_ready) begin lat = c; break; end
    end
    chk("steal_cycle", hc, 5);
    chk("steal_count", holds, 1);
    chk("steal_lat", lat, 6);
    idle_cycle(last_rd);
    chk("steal_cpu_skipped", int'(mem[11'h205]), 0);
    chk("steal_cpu_before", int'(mem[11'h204]), 'h84);
    chk("steal_cpu_after", int'(mem[11'h206]), 'h86);
    chk("steal_hs_mem", int'(mem[11'h300]), 'h3C);

    // Request without hs_access is ignored
    @(posedge clk_sys); #1;
    hs_access = 1'b0; hs_req = 1'b1; hs_write = 1'b1; hs_address = 11'h060;
    hs_data_in = 8'h99;
    @(negedge clk_sys);
    idle_cycle(last_rd);
    chk("noacc_mem", int'(mem[11'h060]), 0);

    // hs_req while busy (in WAIT) is ignored
    txn(1'b1, 11'h050, 8'h12, 3, -1, 2, lat, holds, we_cyc, we_addr);
    chk("inj_wait_lat", lat, 5);
    idle_cycle(last_rd);
    chk("inj_wait_mem", int'(mem[11'h050]), 'h12);
    chk("inj_wait_ignored", int'(mem[11'h051]), 0);

    // hs_req during DONE is ignored
    txn(1'b1, 11'h070, 8'h21, 0, -1, 2, lat, holds, we_cyc, we_addr);
    chk("inj_done_lat", lat, 2);
    idle_cycle(last_rd);
    chk("inj_done_ignored", int'(mem[11'h071]), 0);

    // hs_access dropped in WAIT still completes
    txn(1'b1, 11'h080, 8'h42, 2, 1, -1, lat, holds, we_cyc, we_addr);
    chk("accdrop_lat", lat, 4);
    idle_cycle(last_rd);
    chk("accdrop_mem", int'(mem[11'h080]), 'h42);

    // Reset asserted during RD_LAT drops the read
    for (int c = 0; c < 3; c++) begin
      @(posedge clk_sys); #1;
      hs_access = 1'b1; hs_req = (c == 0); hs_write = 1'b0;
      hs_address = 11'h07F; cpu_ram_en = 1'b0;
      if (c == 2) reset_n = 1'b0;
    end
    #1;
    chk("abort_busy", int'(hs_busy), 0);
    chk("abort_ready", int'(hs_ready), 0);
    chk("abort_data", int'(hs_data_out), 0);
    @(posedge clk_sys); #1;
    reset_n = 1'b1;
    rc = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_sys);
      if (hs_ready || hs_busy) rc++;
    end
    chk("abort_quiet", rc, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hs_ram_responder.md
Name: hs_ram_responder

Overview:
- Target-side responder for the hiscore save/restore engine; sits inside the game core between the CPU work-RAM port and a single-port synchronous work RAM.
- Accepts hiscore read/write requests, slots them into cycles where the CPU is not using RAM, and returns read data with a completion strobe.
- Guarantees forward progress: under sustained CPU traffic it steals one RAM cycle by stalling the CPU for that cycle.

Parameters:
- AW, 11, address width of work RAM and hiscore address.
- DW, 8, data width.
- MAX_WAIT, 64, consecutive CPU-busy cycles tolerated before a forced steal; legal range 1..1023.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- hs_access  in  1  hiscore engine owns the request channel.
- hs_req  in  1  one-cycle request strobe; sampled only when hs_access=1.
- hs_write  in  1  1=write, 0=read; qualified by hs_req.
- hs_address  in  AW  request address; qualified by hs_req.
- hs_data_in  in  DW  write data; qualified by hs_req.
- hs_data_out  out  DW  read data; valid while hs_ready=1, held until next read completes.
- hs_ready  out  1  one-cycle completion strobe for both reads and writes.
- hs_busy  out  1  request in flight (state != IDLE).
- cpu_ram_en  in  1  CPU accesses RAM this cycle.
- cpu_we  in  1  CPU write enable.
- cpu_addr  in  AW  CPU address.
- cpu_din  in  DW  CPU write data.
- cpu_dout  out  DW  RAM read data to CPU (passes ram_dout).
- cpu_hold  out  1  CPU must stall; its access this cycle is not performed.
- ram_addr  out  AW  RAM address.
- ram_din  out  DW  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_dout  in  DW  RAM read data, one-cycle latency after address.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; hs_ready=0, hs_busy=0, hs_data_out=0, wait_cnt=0, latched request cleared. cpu_hold=0. RAM mux selects CPU. This applies mid-operation: in-flight request is dropped with no hs_ready.
- States: IDLE, WAIT, RD_LAT, DONE.
- IDLE: on hs_req & hs_access, latch addr/data/we, go to WAIT. Otherwise stay. hs_req without hs_access is ignored.
- WAIT: grant = ~cpu_ram_en | (wait_cnt == MAX_WAIT). Grant is combinational in the same cycle.
- On grant, RAM is driven from the latched request. Writes assert ram_we=1 and go to DONE. Reads go to RD_LAT.
- Without grant, wait_cnt increments and state stays WAIT.
- cpu_hold = grant & cpu_ram_en. It is high only during a forced-steal cycle and is never high outside WAIT.
- RD_LAT: capture ram_dout into hs_data_out at the cycle end, go to DONE. The CPU owns RAM during this cycle.
- DONE: hs_ready=1 for exactly this cycle; wait_cnt cleared; return to IDLE. A hs_req in DONE is ignored, so the earliest new request is in IDLE.
- Latency with CPU idle: hs_req in cycle 0, grant in cycle 1. hs_ready occurs in cycle 2 for a write and in cycle 3 for a read.
- Worst case with CPU continuously busy: grant occurs at WAIT cycle MAX_WAIT+1.
- When not granted, the RAM mux passes the CPU port: ram_addr=cpu_addr, ram_din=cpu_din, ram_we=cpu_we&cpu_ram_en.
- cpu_dout=ram_dout always. CPU read data after a stolen cycle is undefined; the core wrapper repeats the access.
- hs_req while hs_busy=1: ignored, with no queueing.
- hs_access falling mid-operation: the operation completes and hs_ready still pulses, so RAM writes are never torn.
- wait_cnt width is ceil(log2(MAX_WAIT+1)); it saturates at MAX_WAIT and never wraps.
- Hiscore writes are DW-wide; there are no partial writes.

Test Plan:
- Reset and idle: with reset_n low, then high, and no requests, all outputs are 0 and RAM follows the CPU port exactly for 100 random CPU cycles.
- Idle write: with cpu_ram_en=0, hs_req write addr=0x1A3 data=0x5C → ram_we=1, ram_addr=0x1A3 in cycle 1; hs_ready in cycle 2; the RAM model holds 0x5C.
- Idle read: preload 0x07F=0xA5, hs_req read addr=0x07F → hs_ready in cycle 3 with hs_data_out=0xA5, held after the strobe.
- Starvation: MAX_WAIT=4, cpu_ram_en held 1, hs_req write → cpu_hold=1 for exactly one cycle (WAIT cycle 5); the CPU write that cycle is not performed; hs_ready follows.
- Contention: hs_req during a CPU-busy burst of 3 cycles → grant in the first cpu_ram_en=0 cycle, with no cpu_hold.
- Abort and ignore: hs_req while hs_busy is ignored; reset_n pulsed low in RD_LAT produces no hs_ready and state returns to IDLE; hs_access dropped in WAIT still yields hs_ready.
